// File: rtl/corefifo_rd_flags.sv
// Read-domain pointer and flag controller for the asynchronous COREFIFO.
// Keeps the binary/gray read pointer and derives the empty, almost-empty,
// fill-count and underflow flags from the synchronized gray write pointer.
module corefifo_rd_flags #(
   parameter int ADDRWIDTH = 3,
   parameter int AEVAL     = 2
) (
   input  logic                 clk,
   input  logic                 srstn,
   input  logic                 re,
   input  logic [ADDRWIDTH:0]   wptr_gray_sync,
   output logic [ADDRWIDTH:0]   rptr_gray,
   output logic [ADDRWIDTH-1:0] raddr,
   output logic                 rd_en_mem,
   output logic                 empty,
   output logic                 aempty,
   output logic [ADDRWIDTH:0]   rdcnt,
   output logic                 underflow
);

   localparam logic [ADDRWIDTH:0] AEVAL_W = AEVAL[ADDRWIDTH:0];

   logic [ADDRWIDTH:0] rptr_bin;
   logic [ADDRWIDTH:0] rptr_bin_next;
   logic [ADDRWIDTH:0] rptr_gray_next;
   logic [ADDRWIDTH:0] wptr_bin;
   logic [ADDRWIDTH:0] cnt_next;
   logic               rd_acc;
   // Low during reset and for the first edge after release, so a read
   // request that meets the reset-forced empty flag is not flagged.
   logic               run_q;

   assign rd_acc    = re & ~empty;
   assign rd_en_mem = rd_acc;
   assign raddr     = rptr_bin[ADDRWIDTH-1:0];

   // Gray-to-binary decode of the synchronized write pointer, MSB first
   always_comb begin
      wptr_bin = '0;
      wptr_bin[ADDRWIDTH] = wptr_gray_sync[ADDRWIDTH];
      for (int i = ADDRWIDTH - 1; i >= 0; i--)
         wptr_bin[i] = wptr_bin[i+1] ^ wptr_gray_sync[i];
   end

   // Next read pointer, its gray form and the resulting fill count
   always_comb begin
      rptr_bin_next  = rptr_bin + {{ADDRWIDTH{1'b0}}, rd_acc};
      rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);
      cnt_next       = wptr_bin - rptr_bin_next;
   end

   // Pointer and flag registers; flags always reflect the post-read pointer
   always_ff @(posedge clk) begin
      if (!srstn) begin
         rptr_bin  <= '0;
         rptr_gray <= '0;
         empty     <= 1'b1;
         aempty    <= 1'b1;
         rdcnt     <= '0;
         underflow <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         rptr_bin  <= rptr_bin_next;
         rptr_gray <= rptr_gray_next;
         empty     <= (rptr_gray_next == wptr_gray_sync);
         aempty    <= (cnt_next <= AEVAL_W);
         rdcnt     <= cnt_next;
         underflow <= re & empty & run_q;
         run_q     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_corefifo_rd_flags.sv
// Directed + short random bench for corefifo_rd_flags (ADDRWIDTH=3, AEVAL=2).
// A behavioural model pushes the expected post-edge state per step into a
// queue; it is popped and compared after the edge, alongside directed checks.
module tb_corefifo_rd_flags;

   logic       clk = 1'b0;
   logic       srstn;
   logic       re;
   logic [3:0] wptr_gray_sync;
   logic [3:0] rptr_gray;
   logic [2:0] raddr;
   logic       rd_en_mem;
   logic       empty;
   logic       aempty;
   logic [3:0] rdcnt;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] gray;
      logic [2:0] addr;
      logic       emp;
      logic       aemp;
      logic [3:0] cnt;
      logic       uf;
   } exp_t;

   exp_t sb[$];

   // model state
   logic [3:0] m_rptr  = '0;
   logic       m_empty = 1'b1;
   logic       m_run   = 1'b0;

   corefifo_rd_flags #(.ADDRWIDTH(3), .AEVAL(2)) dut (
      .clk(clk), .srstn(srstn), .re(re), .wptr_gray_sync(wptr_gray_sync),
      .rptr_gray(rptr_gray), .raddr(raddr), .rd_en_mem(rd_en_mem),
      .empty(empty), .aempty(aempty), .rdcnt(rdcnt), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b = '0;
      for (int i = 0; i < 4; i++) b = b ^ (g >> i);
      return b;
   endfunction

   // Drive one cycle of inputs, predict the post-edge state, then compare.
   task automatic step(input logic r, input logic rn, input logic [3:0] wg);
      exp_t e, o;
      logic [3:0] nr;
      re = r; srstn = rn; wptr_gray_sync = wg;
      #1;
      chk("rd_en_mem", {7'd0, rd_en_mem}, {7'd0, r & ~m_empty});
      if (!rn) begin
         nr = '0;
         e.emp = 1'b1; e.aemp = 1'b1; e.cnt = '0; e.uf = 1'b0;
      end else begin
         nr = m_rptr + {3'd0, r & ~m_empty};
         e.cnt  = g2b(wg) - nr;
         e.emp  = (e.cnt == 4'd0);
         e.aemp = (e.cnt <= 4'd2);
         e.uf   = r & m_empty & m_run;
      end
      e.gray = nr ^ (nr >> 1);
      e.addr = nr[2:0];
      sb.push_back(e);
      m_rptr = nr; m_empty = e.emp; m_run = rn;
      @(posedge clk); #1;
      o = sb.pop_front();
      chk("sb_gray",   {4'd0, rptr_gray}, {4'd0, o.gray});
      chk("sb_raddr",  {5'd0, raddr},     {5'd0, o.addr});
      chk("sb_empty",  {7'd0, empty},     {7'd0, o.emp});
      chk("sb_aempty", {7'd0, aempty},    {7'd0, o.aemp});
      chk("sb_rdcnt",  {4'd0, rdcnt},     {4'd0, o.cnt});
      chk("sb_uflow",  {7'd0, underflow}, {7'd0, o.uf});
   endtask

   initial begin
      logic [2:0] seq [8];
      srstn = 1'b0; re = 1'b1; wptr_gray_sync = 4'b0000;
      @(posedge clk); #1;

      // reset held two edges with re=1
      step(1'b1, 1'b0, 4'b0000);
      step(1'b1, 1'b0, 4'b0000);
      chk("rst_empty",  {7'd0, empty},     8'd1);
      chk("rst_aempty", {7'd0, aempty},    8'd1);
      chk("rst_rdcnt",  {4'd0, rdcnt},     8'd0);
      chk("rst_gray",   {4'd0, rptr_gray}, 8'd0);
      chk("rst_raddr",  {5'd0, raddr},     8'd0);
      chk("rst_uflow",  {7'd0, underflow}, 8'd0);
      chk("rst_rden",   {7'd0, rd_en_mem}, 8'd0);

      // first edge after release with re=1: no underflow
      step(1'b1, 1'b1, 4'b0000);
      chk("rel_uflow", {7'd0, underflow}, 8'd0);

      // fill visibility: wptr = 5
      step(1'b0, 1'b1, 4'b0111);
      chk("fill_empty",  {7'd0, empty},  8'd0);
      chk("fill_rdcnt",  {4'd0, rdcnt},  8'd5);
      chk("fill_aempty", {7'd0, aempty}, 8'd0);

      // drain five words
      for (int i = 0; i < 5; i++) begin
         chk("drain_raddr", {5'd0, raddr}, 8'(i));
         step(1'b1, 1'b1, 4'b0111);
         chk("drain_rdcnt",  {4'd0, rdcnt},  8'(4 - i));
         chk("drain_aempty", {7'd0, aempty}, (4 - i <= 2) ? 8'd1 : 8'd0);
      end
      chk("drain_raddr_end", {5'd0, raddr},     8'd5);
      chk("drain_empty",     {7'd0, empty},     8'd1);
      chk("drain_gray",      {4'd0, rptr_gray}, 8'b0111);
      chk("drain_rden",      {7'd0, rd_en_mem}, 8'd0);

      // read while empty, two cycles
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 4'b0111);
         chk("uf_pulse", {7'd0, underflow}, 8'd1);
         chk("uf_gray",  {4'd0, rptr_gray}, 8'b0111);
         chk("uf_rdcnt", {4'd0, rdcnt},     8'd0);
      end

      // advance read pointer to 12 (gray 1010)
      step(1'b0, 1'b1, 4'b1010);
      chk("uf_clear", {7'd0, underflow}, 8'd0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 4'b1010);
      chk("wrap_gray12", {4'd0, rptr_gray}, 8'b1010);
      chk("wrap_empty12", {7'd0, empty},    8'd1);

      // full: wptr = 4 (gray 0110), pointers differ only in MSB
      step(1'b0, 1'b1, 4'b0110);
      chk("full_rdcnt", {4'd0, rdcnt}, 8'd8);
      chk("full_empty", {7'd0, empty}, 8'd0);
      seq = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
      for (int i = 0; i < 8; i++) begin
         chk("wrap_raddr", {5'd0, raddr}, {5'd0, seq[i]});
         step(1'b1, 1'b1, 4'b0110);
      end
      chk("wrap_raddr_end", {5'd0, raddr},     8'd4);
      chk("wrap_empty",     {7'd0, empty},     8'd1);
      chk("wrap_gray",      {4'd0, rptr_gray}, 8'b0110);

      // reset mid-read: rptr=4, wptr=7 (gray 0100) -> count 3
      step(1'b0, 1'b1, 4'b0100);
      chk("mid_rdcnt", {4'd0, rdcnt}, 8'd3);
      step(1'b1, 1'b0, 4'b0100);
      chk("mid_rst_empty", {7'd0, empty},     8'd1);
      chk("mid_rst_rdcnt", {4'd0, rdcnt},     8'd0);
      chk("mid_rst_gray",  {4'd0, rptr_gray}, 8'd0);
      chk("mid_rst_raddr", {5'd0, raddr},     8'd0);
      chk("mid_rst_uflow", {7'd0, underflow}, 8'd0);
      step(1'b0, 1'b1, 4'b0100);
      chk("mid_resume_rdcnt", {4'd0, rdcnt},  8'd7);
      chk("mid_resume_empty", {7'd0, empty},  8'd0);
      chk("mid_resume_aempty", {7'd0, aempty}, 8'd0);

      // random pointer jumps and reads, model-checked
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
